// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with registered one-hot grant and index.
// Optional forced release after MAX_HOLD busy cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [7:0] i_req,
  input  logic       i_done,
  output logic [7:0] o_gnt,
  output logic [2:0] o_gnt_idx,
  output logic       o_gnt_valid,
  output logic       o_timeout
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be within 2..256");
  end

  state_t     r_state, w_state_nx;
  logic [7:0] r_gnt, w_gnt_nx;
  logic [2:0] r_idx, w_idx_nx;
  logic [2:0] r_last, w_last_nx;
  logic       r_timeout, w_timeout_nx;
  logic       w_found;
  logic [2:0] w_sel;
  logic       w_release;

  // Search starts just past the last owner; k=8 wraps back onto the last owner itself.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last;
    for (int k = 1; k <= 8; k++) begin
      if (!w_found && i_req[r_last + 3'(k)]) begin
        w_found = 1'b1;
        w_sel   = r_last + 3'(k);
      end
    end
  end

  assign w_release = i_done | ~i_req[r_idx] | ~i_en;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_hold_cnt, w_hold_cnt_nx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_hold_cnt <= 8'd0;
    else       r_hold_cnt <= w_hold_cnt_nx;
  end
`endif

  always_comb begin
    w_state_nx   = r_state;
    w_gnt_nx     = r_gnt;
    w_idx_nx     = r_idx;
    w_last_nx    = r_last;
    w_timeout_nx = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_hold_cnt_nx = r_hold_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_en && w_found) begin
          w_state_nx = S_BUSY;
          w_gnt_nx   = 8'd1 << w_sel;
          w_idx_nx   = w_sel;
`ifdef ARB_TIMEOUT_EN
          w_hold_cnt_nx = 8'd0;
`endif
        end
      end
      S_BUSY: begin
        if (w_release) begin
          w_state_nx = S_IDLE;
          w_gnt_nx   = 8'd0;
          w_last_nx  = r_idx;
        end
`ifdef ARB_TIMEOUT_EN
        // A normal release in the same cycle wins, so no timeout pulse then.
        else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nx   = S_IDLE;
          w_gnt_nx     = 8'd0;
          w_last_nx    = r_idx;
          w_timeout_nx = 1'b1;
        end else begin
          w_hold_cnt_nx = r_hold_cnt + 8'd1;
        end
`endif
      end
      default: begin
        w_state_nx = S_IDLE;
        w_gnt_nx   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= 8'd0;
      r_idx     <= 3'd0;
      r_last    <= 3'd7;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_gnt     <= w_gnt_nx;
      r_idx     <= w_idx_nx;
      r_last    <= w_last_nx;
      r_timeout <= w_timeout_nx;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_idx   = r_idx;
  assign o_gnt_valid = (r_state == S_BUSY);
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - self-checking bench for rr_arbiter8.
// Exercises ARB_TIMEOUT_EN behaviour with MAX_HOLD=4 when that macro is defined.
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] o_gnt;
  logic [2:0] o_gnt_idx;
  logic       o_gnt_valid;
  logic       o_timeout;

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req), .i_done(done),
    .o_gnt(o_gnt), .o_gnt_idx(o_gnt_idx), .o_gnt_valid(o_gnt_valid), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
  } vec_t;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  vec_t vecs[18];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".gnt"}, 32'(o_gnt), 32'(e.gnt));
    chk({tag, ".idx"}, 32'(o_gnt_idx), 32'(e.idx));
    chk({tag, ".valid"}, 32'(o_gnt_valid), 32'(e.valid));
    chk({tag, ".timeout"}, 32'(o_timeout), 32'(e.to));
    chk({tag, ".inv"}, 32'((o_gnt_valid == |o_gnt) && (!o_gnt_valid || o_gnt == (8'd1 << o_gnt_idx))), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [7:0] r, input logic d);
    en = e; req = r; done = d;
  endtask

  // Push the expectation for the coming edge, clock, then pop and compare.
  task automatic step_exp(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v, input logic to);
    exp_t e;
    sb.push_back('{g, i, v, to});
    tick();
    e = sb.pop_front();
    chk_out(tag, e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // en, req, done -> gnt, idx, valid (starting from reset, last=7)
    vecs[0]  = '{1'b1, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1};
    vecs[1]  = '{1'b1, 8'h01, 1'b1, 8'h00, 3'd0, 1'b0};
    vecs[2]  = '{1'b1, 8'hFF, 1'b0, 8'h02, 3'd1, 1'b1};
    vecs[3]  = '{1'b1, 8'hFF, 1'b1, 8'h00, 3'd1, 1'b0};
    vecs[4]  = '{1'b1, 8'hFF, 1'b0, 8'h04, 3'd2, 1'b1};
    vecs[5]  = '{1'b1, 8'hFF, 1'b0, 8'h04, 3'd2, 1'b1};
    vecs[6]  = '{1'b1, 8'hFB, 1'b0, 8'h00, 3'd2, 1'b0};
    vecs[7]  = '{1'b1, 8'h09, 1'b0, 8'h08, 3'd3, 1'b1};
    vecs[8]  = '{1'b1, 8'h09, 1'b1, 8'h00, 3'd3, 1'b0};
    vecs[9]  = '{1'b1, 8'h09, 1'b0, 8'h01, 3'd0, 1'b1};
    vecs[10] = '{1'b0, 8'h09, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[11] = '{1'b0, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[12] = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[13] = '{1'b1, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1};
    vecs[14] = '{1'b1, 8'h81, 1'b1, 8'h00, 3'd7, 1'b0};
    vecs[15] = '{1'b1, 8'h81, 1'b0, 8'h01, 3'd0, 1'b1};
    vecs[16] = '{1'b1, 8'h80, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[17] = '{1'b1, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1};

    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    repeat (2) tick();
    chk_out("reset", '{8'h00, 3'd0, 1'b0, 1'b0});
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].en, vecs[i].req, vecs[i].done);
      step_exp($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].valid, 1'b0);
    end

    // Full contention: order 0..7,0 with an idle cycle after each release.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 8'hFF, 1'b0);
      step_exp($sformatf("rr%0d.grant", k), 8'd1 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
      drive(1'b1, 8'hFF, 1'b1);
      step_exp($sformatf("rr%0d.idle", k), 8'h00, 3'(k % 8), 1'b0, 1'b0);
    end

    // last=0 now: grant 2, then en=0 releases and blocks arbitration.
    drive(1'b1, 8'h04, 1'b0);
    step_exp("en.grant", 8'h04, 3'd2, 1'b1, 1'b0);
    drive(1'b0, 8'h04, 1'b0);
    step_exp("en.release", 8'h00, 3'd2, 1'b0, 1'b0);
    drive(1'b0, 8'hFF, 1'b0);
    for (int k = 0; k < 5; k++) step_exp($sformatf("en.blocked%0d", k), 8'h00, 3'd2, 1'b0, 1'b0);

    // last=2: req bit 5 only -> grant 5, then async reset mid-cycle.
    drive(1'b1, 8'h20, 1'b0);
    step_exp("rst.grant", 8'h20, 3'd5, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk_out("rst.async", '{8'h00, 3'd0, 1'b0, 1'b0});
    drive(1'b1, 8'h21, 1'b0);
    tick();
    rst = 1'b0;
    step_exp("rst.prio0", 8'h01, 3'd0, 1'b1, 1'b0);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    drive(1'b1, 8'h04, 1'b0);
    for (int k = 0; k < 4; k++) step_exp($sformatf("to.hold%0d", k), 8'h04, 3'd2, 1'b1, 1'b0);
    step_exp("to.pulse", 8'h00, 3'd2, 1'b0, 1'b1);
    step_exp("to.regrant", 8'h04, 3'd2, 1'b1, 1'b0);
    drive(1'b1, 8'h04, 1'b1);
    step_exp("to.done_release", 8'h00, 3'd2, 1'b0, 1'b0);
`else
    do_reset();
    drive(1'b1, 8'h04, 1'b0);
    for (int k = 0; k < 20; k++) step_exp($sformatf("hold%0d", k), 8'h04, 3'd2, 1'b1, 1'b0);
    drive(1'b1, 8'h04, 1'b1);
    step_exp("hold.release", 8'h00, 3'd2, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter that shares one resource.
- Issues a registered one-hot grant plus a 3-bit index, so the grant vector has the same encoding as the 3-to-8 decoder output in the team's datapath.
- Grant is held until the owner signals done or drops its request.
- At most one grant active at any time; one idle cycle between grants.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles a grant may be held. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..256.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- en  in  1  arbiter enable; 0 forces no grant, like the decoder enable
- req  in  8  request vector; bit i = requester i
- done  in  1  owner finished; releases grant
- gnt  out  8  one-hot grant, all-zero when no grant
- gnt_idx  out  3  binary index of the granted requester; holds the last value when idle
- gnt_valid  out  1  grant active (equals OR of gnt)
- timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - last pointer=3'd7, so requester 0 has first priority.
- Outputs are registered and change only on a clk rising edge or on rst.
- State IDLE:
  - If en=1 and req!=0, select the first set req bit searching (last+1) mod 8 upward with wrap 7->0.
  - Next edge: state=BUSY, gnt_idx=selected, gnt=1<<selected, gnt_valid=1.
  - Latency from req high (sampled) to gnt high: 1 cycle.
- State BUSY: release condition = done=1 OR req[gnt_idx]=0 OR en=0.
  - On release, next edge: state=IDLE, gnt=0, gnt_valid=0, last=gnt_idx; gnt_idx keeps its value.
  - Without release, all outputs hold.
- No back-to-back grants: after a release, at least one cycle with gnt_valid=0 before the next grant.
- Fairness: a requester that keeps req high is granted within 8 grants.
- Simultaneous events:
  - done together with new requests: release first; arbitration happens in the following IDLE cycle using the updated last pointer.
  - Requests from non-owners while BUSY are ignored; they are not latched.
- Single requester: after its release it is re-granted after the mandatory idle cycle (wrap search finds it).
- req=0 in IDLE: stay IDLE, last pointer unchanged.
- en=0: immediate release from BUSY; IDLE does not arbitrate. last still updates on the release.
- rst asserted mid-grant: outputs clear immediately (asynchronously); priority returns to requester 0.
- gnt is never multi-hot and never X. Invariant: gnt_valid == |gnt, and gnt == (1<<gnt_idx) whenever gnt_valid=1.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - An 8-bit hold counter clears on grant and increments each BUSY cycle.
  - If the counter reaches MAX_HOLD-1 with no release, force a release on the next edge (same effect as done), and pulse timeout=1 for that one cycle.
  - Normal release has priority; timeout stays 0 if done arrives the same cycle.
- Undefined: no counter is built, timeout is tied 0, and the grant may be held indefinitely.

Test Plan:
- Reset then req=8'h01, en=1 -> one cycle later gnt=8'h01, gnt_idx=0, gnt_valid=1. Pulse done -> next cycle gnt=0.
- req=8'hFF held, done pulsed each grant -> grant order 0,1,2,...,7,0 with one idle cycle between grants.
- last=3 after a grant, then req=8'h09 (bits 0,3) -> next grant idx 0, because the search order is 4..7,0.
- During a grant to idx 2, drop en to 0 -> next edge gnt=0. With en=0, req=8'hFF -> no grant for 5 cycles.
- Assert rst mid-grant to idx 5 -> gnt=0 immediately, before the clock edge. Release rst with req=8'h21 -> first grant idx 0.
- ARB_TIMEOUT_EN, MAX_HOLD=4: req=8'h04 held, done=0 -> gnt high 4 cycles, then gnt=0 with timeout=1 for exactly 1 cycle, then re-grant to idx 2.
